// File: rtl/fill_arb_pkg.sv
// fill_arb_pkg: FSM state encoding, owner codes and bus size codes shared by fill_arb and its beat counter.
package fill_arb_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [1:0] OWN_IC = 2'd1;
  localparam logic [1:0] OWN_DC = 2'd2;
  localparam logic [1:0] OWN_UNC = 2'd3;
  localparam logic [2:0] SZ_BEAT = 3'd7;
  function automatic logic [2:0] last_idx(input int beats);
    return 3'(beats - 1);
  endfunction
endpackage

// File: rtl/fill_arb_beat_ctr.sv
// fill_beat_ctr: beat index within a line; loads a start offset and wraps modulo the line length.
module fill_beat_ctr (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [2:0] start_i,
  input  logic [2:0] last_i,
  input  logic       inc_i,
  output logic [2:0] idx_o
);
  logic [2:0] idx_q, idx_d, mask_q, mask_d;
  always_comb begin
    idx_d = load_i ? start_i : inc_i ? (idx_q + 3'd1) & mask_q : idx_q;
    mask_d = load_i ? last_i : mask_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      idx_q <= '0;
      mask_q <= '0;
    end else begin
      idx_q <= idx_d;
      mask_q <= mask_d;
    end
  assign idx_o = idx_q;
endmodule

// File: rtl/fill_arb.sv
// fill_arb: non-preemptive arbiter issuing icache/dcache line fills and uncached accesses on the memory bus.
// Define FILL_ARB_CRITWORD_EN for critical-word-first wrapping fills.
module fill_arb
  import fill_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int ILINE_BEATS = 4,
  parameter int DLINE_BEATS = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          icfill_req_i,
  input  logic [AW-1:0] icfill_pa_i,
  output logic          icbusy_o,
  output logic          icdone_o,
  output logic          icerror_o,
  input  logic          dcfill_req_i,
  input  logic [AW-1:0] dcfill_pa_i,
  output logic          dcbusy_o,
  output logic          dcdone_o,
  output logic          dcerror_o,
  input  logic          unc_req_i,
  input  logic          unc_we_i,
  input  logic [AW-1:0] unc_pa_i,
  input  logic [2:0]    unc_sz_i,
  input  logic [DW-1:0] unc_wdata_i,
  output logic [DW-1:0] fill_data_o,
  output logic [2:0]    fill_idx_o,
  output logic          ic_wen_o,
  output logic          dc_wen_o,
  output logic          bus_req_o,
  input  logic          bus_ack_i,
  output logic [AW-1:0] bus_addr_o,
  output logic [3:0]    bus_len_o,
  output logic          bus_we_o,
  output logic [2:0]    bus_sz_o,
  output logic [DW-1:0] bus_wdata_o,
  input  logic          bus_rvalid_i,
  input  logic [DW-1:0] bus_rdata_i,
  input  logic          bus_rlast_i,
  input  logic          bus_err_i
);
  localparam int BOFF = $clog2(DW / 8);
  localparam logic [AW-1:0] BEAT_MASK = ~AW'(DW / 8 - 1);
  localparam logic [AW-1:0] ILINE_MASK = ~AW'(ILINE_BEATS * DW / 8 - 1);
  localparam logic [AW-1:0] DLINE_MASK = ~AW'(DLINE_BEATS * DW / 8 - 1);
  localparam logic [2:0] ILAST = last_idx(ILINE_BEATS);
  localparam logic [2:0] DLAST = last_idx(DLINE_BEATS);
  logic [1:0] state_q, state_d, own_q, own_d;
  logic [AW-1:0] ic_addr, dc_addr, addr_d, addr_q;
  logic [2:0] ic_start, dc_start, start_d, last_d, sz_q, ctr_idx, fill_idx_q;
  logic [3:0] len_q;
  logic [DW-1:0] wdata_q, fill_data_q;
  logic grant, beat, fin, we_q, err_q, bus_req_q;
  logic icbusy_q, icdone_q, icerror_q, dcbusy_q, dcdone_q, dcerror_q, ic_wen_q, dc_wen_q;
`ifdef FILL_ARB_CRITWORD_EN
  assign ic_addr = icfill_pa_i & BEAT_MASK;
  assign dc_addr = dcfill_pa_i & BEAT_MASK;
  assign ic_start = 3'(icfill_pa_i >> BOFF) & ILAST;
  assign dc_start = 3'(dcfill_pa_i >> BOFF) & DLAST;
`else
  assign ic_addr = icfill_pa_i & ILINE_MASK;
  assign dc_addr = dcfill_pa_i & DLINE_MASK;
  assign ic_start = '0;
  assign dc_start = '0;
`endif
  always_comb begin
    grant = state_q == S_IDLE && (unc_req_i || dcfill_req_i || icfill_req_i);
    own_d = unc_req_i ? OWN_UNC : dcfill_req_i ? OWN_DC : OWN_IC;
    addr_d = unc_req_i ? unc_pa_i : dcfill_req_i ? dc_addr : ic_addr;
    last_d = unc_req_i ? 3'd0 : dcfill_req_i ? DLAST : ILAST;
    start_d = unc_req_i ? 3'd0 : dcfill_req_i ? dc_start : ic_start;
    beat = state_q == S_DATA && bus_rvalid_i;
    fin = beat && bus_rlast_i;
    state_d = state_q == S_IDLE ? (grant ? S_ADDR : S_IDLE) :
              state_q == S_ADDR ? (bus_ack_i ? S_DATA : S_ADDR) :
              state_q == S_DATA ? (fin ? S_DONE : S_DATA) : S_IDLE;
  end
  fill_beat_ctr u_ctr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (grant),
    .start_i(start_d),
    .last_i (last_d),
    .inc_i  (beat),
    .idx_o  (ctr_idx)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= S_IDLE;
      own_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      sz_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      err_q <= 1'b0;
      bus_req_q <= 1'b0;
      fill_data_q <= '0;
      fill_idx_q <= '0;
      {icbusy_q, icdone_q, icerror_q, dcbusy_q, dcdone_q, dcerror_q, ic_wen_q, dc_wen_q} <= '0;
    end else begin
      state_q <= state_d;
      ic_wen_q <= beat && own_q == OWN_IC;
      dc_wen_q <= beat && own_q != OWN_IC && !we_q;
      icdone_q <= fin && own_q == OWN_IC;
      dcdone_q <= fin && own_q != OWN_IC;
      icerror_q <= fin && own_q == OWN_IC && (err_q || bus_err_i);
      dcerror_q <= fin && own_q != OWN_IC && (err_q || bus_err_i);
      if (grant) begin
        own_q <= own_d;
        addr_q <= addr_d;
        len_q <= {1'b0, last_d};
        sz_q <= unc_req_i ? unc_sz_i : SZ_BEAT;
        we_q <= unc_req_i && unc_we_i;
        wdata_q <= unc_wdata_i;
        err_q <= 1'b0;
        bus_req_q <= 1'b1;
        icbusy_q <= own_d == OWN_IC;
        dcbusy_q <= own_d != OWN_IC;
      end
      if (state_q == S_ADDR && bus_ack_i) bus_req_q <= 1'b0;
      if (beat) begin
        fill_data_q <= bus_rdata_i;
        fill_idx_q <= ctr_idx;
        err_q <= err_q || bus_err_i;
      end
      // busy covers the DONE cycle and drops as the FSM returns to IDLE
      if (state_q == S_DONE) begin
        icbusy_q <= 1'b0;
        dcbusy_q <= 1'b0;
      end
    end
  assign icbusy_o = icbusy_q;
  assign icdone_o = icdone_q;
  assign icerror_o = icerror_q;
  assign dcbusy_o = dcbusy_q;
  assign dcdone_o = dcdone_q;
  assign dcerror_o = dcerror_q;
  assign ic_wen_o = ic_wen_q;
  assign dc_wen_o = dc_wen_q;
  assign fill_data_o = fill_data_q;
  assign fill_idx_o = fill_idx_q;
  assign bus_req_o = bus_req_q;
  assign bus_addr_o = addr_q;
  assign bus_len_o = len_q;
  assign bus_we_o = we_q;
  assign bus_sz_o = sz_q;
  assign bus_wdata_o = wdata_q;
endmodule

// File: tb/tb_fill_arb.sv
// tb_fill_arb: table-driven bench for fill_arb plus hand sequences for reset and critical-word fills.
module tb_fill_arb;
  logic clk = 1'b0, rst_n = 1'b0;
  logic icfill_req = 0, dcfill_req = 0, unc_req = 0, unc_we = 0;
  logic [31:0] icfill_pa = 0, dcfill_pa = 0, unc_pa = 0;
  logic [2:0] unc_sz = 0;
  logic [63:0] unc_wdata = 0, bus_rdata = 0;
  logic bus_ack = 0, bus_rvalid = 0, bus_rlast = 0, bus_err = 0;
  logic icbusy, icdone, icerror, dcbusy, dcdone, dcerror, ic_wen, dc_wen, bus_req, bus_we;
  logic [63:0] fill_data, bus_wdata;
  logic [2:0] fill_idx, bus_sz;
  logic [31:0] bus_addr;
  logic [3:0] bus_len;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  fill_arb dut (
    .clk_i(clk), .rst_ni(rst_n),
    .icfill_req_i(icfill_req), .icfill_pa_i(icfill_pa),
    .icbusy_o(icbusy), .icdone_o(icdone), .icerror_o(icerror),
    .dcfill_req_i(dcfill_req), .dcfill_pa_i(dcfill_pa),
    .dcbusy_o(dcbusy), .dcdone_o(dcdone), .dcerror_o(dcerror),
    .unc_req_i(unc_req), .unc_we_i(unc_we), .unc_pa_i(unc_pa), .unc_sz_i(unc_sz), .unc_wdata_i(unc_wdata),
    .fill_data_o(fill_data), .fill_idx_o(fill_idx), .ic_wen_o(ic_wen), .dc_wen_o(dc_wen),
    .bus_req_o(bus_req), .bus_ack_i(bus_ack), .bus_addr_o(bus_addr), .bus_len_o(bus_len),
    .bus_we_o(bus_we), .bus_sz_o(bus_sz), .bus_wdata_o(bus_wdata),
    .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata), .bus_rlast_i(bus_rlast), .bus_err_i(bus_err)
  );

`ifdef FILL_ARB_CRITWORD_EN
  localparam int ICS = 2, DCS = 1, ICA = 'h1230, DCA = 'h1238;
`else
  localparam int ICS = 0, DCS = 0, ICA = 'h1220, DCA = 'h1230;
`endif

  typedef struct {
    int ic, dc, un, ack, rv, rl, er;
    int breq, icb, icd, ice, dcb, dcd, icw, dcw;
    int idx, addr, len, we, sz;
  } vec_t;
  vec_t tv[26];

  function automatic logic [7:0] status();
    return {bus_req, icbusy, icdone, icerror, dcbusy, dcdone, ic_wen, dc_wen};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        ic dc un ak rv rl er | rq icb icd ice dcb dcd icw dcw | idx addr len we sz
    tv[0]  = '{1,0,0,0,0,0,0, 1,1,0,0,0,0,0,0, 0,ICA,3,0,7};
    tv[1]  = '{1,0,0,0,0,0,0, 1,1,0,0,0,0,0,0, 0,ICA,3,0,7};
    tv[2]  = '{1,0,0,1,0,0,0, 0,1,0,0,0,0,0,0, 0,ICA,3,0,7};
    tv[3]  = '{1,0,0,0,1,0,0, 0,1,0,0,0,0,1,0, ICS,ICA,3,0,7};
    tv[4]  = '{1,0,0,0,0,0,0, 0,1,0,0,0,0,0,0, ICS,ICA,3,0,7};
    tv[5]  = '{1,0,0,0,1,0,0, 0,1,0,0,0,0,1,0, (ICS+1)%4,ICA,3,0,7};
    tv[6]  = '{1,0,0,0,1,0,0, 0,1,0,0,0,0,1,0, (ICS+2)%4,ICA,3,0,7};
    tv[7]  = '{0,0,0,0,1,1,0, 0,1,1,0,0,0,1,0, (ICS+3)%4,ICA,3,0,7};
    tv[8]  = '{0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0, (ICS+3)%4,ICA,3,0,7};
    tv[9]  = '{1,1,0,0,0,0,0, 1,0,0,0,1,0,0,0, (ICS+3)%4,DCA,1,0,7};
    tv[10] = '{1,1,0,1,0,0,0, 0,0,0,0,1,0,0,0, (ICS+3)%4,DCA,1,0,7};
    tv[11] = '{1,1,0,0,1,0,0, 0,0,0,0,1,0,0,1, DCS,DCA,1,0,7};
    tv[12] = '{1,0,0,0,1,1,0, 0,0,0,0,1,1,0,1, (DCS+1)%2,DCA,1,0,7};
    tv[13] = '{1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0, (DCS+1)%2,DCA,1,0,7};
    tv[14] = '{1,0,0,0,0,0,0, 1,1,0,0,0,0,0,0, (DCS+1)%2,ICA,3,0,7};
    tv[15] = '{1,0,0,1,0,0,0, 0,1,0,0,0,0,0,0, (DCS+1)%2,ICA,3,0,7};
    tv[16] = '{1,0,0,0,1,0,0, 0,1,0,0,0,0,1,0, ICS,ICA,3,0,7};
    tv[17] = '{1,0,0,0,1,0,1, 0,1,0,0,0,0,1,0, (ICS+1)%4,ICA,3,0,7};
    tv[18] = '{1,0,0,0,1,0,0, 0,1,0,0,0,0,1,0, (ICS+2)%4,ICA,3,0,7};
    tv[19] = '{0,0,0,0,1,1,0, 0,1,1,1,0,0,1,0, (ICS+3)%4,ICA,3,0,7};
    tv[20] = '{0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0, (ICS+3)%4,ICA,3,0,7};
    tv[21] = '{0,1,1,0,0,0,0, 1,0,0,0,1,0,0,0, (ICS+3)%4,'h100,0,1,3};
    tv[22] = '{0,1,1,1,0,0,0, 0,0,0,0,1,0,0,0, (ICS+3)%4,'h100,0,1,3};
    tv[23] = '{0,1,0,0,1,1,0, 0,0,0,0,1,1,0,0, 0,'h100,0,1,3};
    tv[24] = '{0,1,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,'h100,0,1,3};
    tv[25] = '{0,1,0,0,0,0,0, 1,0,0,0,1,0,0,0, 0,DCA,1,0,7};
    icfill_pa = 32'h1234;
    dcfill_pa = 32'h1238;
    unc_pa = 32'h100;
    unc_sz = 3'd3;
    unc_we = 1'b1;
    unc_wdata = 64'hdeadbeef;
    repeat (3) @(posedge clk);
    #1;
    check("reset_status", status(), 8'h00);
    check("reset_bus", {bus_addr, bus_len, bus_we, bus_sz, fill_idx}, '0);
    check("reset_data", {fill_data, bus_wdata}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 26; i++) begin
      icfill_req = tv[i].ic[0];
      dcfill_req = tv[i].dc[0];
      unc_req = tv[i].un[0];
      bus_ack = tv[i].ack[0];
      bus_rvalid = tv[i].rv[0];
      bus_rlast = tv[i].rl[0];
      bus_err = tv[i].er[0];
      bus_rdata = 64'h100 + 64'(i);
      tick();
      check($sformatf("row%0d_status", i), status(),
            {tv[i].breq[0], tv[i].icb[0], tv[i].icd[0], tv[i].ice[0],
             tv[i].dcb[0], tv[i].dcd[0], tv[i].icw[0], tv[i].dcw[0]});
      check($sformatf("row%0d_idx", i), fill_idx, tv[i].idx[2:0]);
      check($sformatf("row%0d_bus", i), {bus_addr, bus_len, bus_we, bus_sz},
            {tv[i].addr[31:0], tv[i].len[3:0], tv[i].we[0], tv[i].sz[2:0]});
      if (tv[i].icw != 0 || tv[i].dcw != 0)
        check($sformatf("row%0d_data", i), fill_data, 64'h100 + 64'(i));
      if (tv[i].we != 0)
        check($sformatf("row%0d_wdata", i), bus_wdata, 64'hdeadbeef);
    end
    {icfill_req, dcfill_req, unc_req, bus_rvalid, bus_rlast, bus_err} = '0;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata = 64'h55;
    tick();
    check("pre_reset_dcw", {dc_wen, dcbusy, fill_data[7:0]}, {1'b1, 1'b1, 8'h55});
    bus_rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_status", status(), 8'h00);
    check("async_reset_bus", {bus_addr, bus_len, bus_we, bus_sz, fill_idx}, '0);
    check("async_reset_data", fill_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    icfill_req = 1'b1;
    tick();
    check("post_reset_grant", {status(), bus_addr, bus_len}, {8'hc0, ICA[31:0], 4'd3});
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    bus_rvalid = 1'b1;
    bus_rlast = 1'b1;
    bus_rdata = 64'h77;
    icfill_req = 1'b0;
    tick();
    check("post_reset_done", {status(), fill_idx, fill_data}, {8'h62, ICS[2:0], 64'h77});
    {bus_rvalid, bus_rlast} = '0;
    tick();
    check("post_reset_idle", status(), 8'h00);
`ifdef FILL_ARB_CRITWORD_EN
    dcfill_pa = 32'h108;
    dcfill_req = 1'b1;
    tick();
    check("crit_addr", {bus_addr, bus_len}, {32'h108, 4'd1});
    dcfill_req = 1'b0;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    bus_rvalid = 1'b1;
    tick();
    check("crit_beat0", {dc_wen, fill_idx}, {1'b1, 3'd1});
    bus_rlast = 1'b1;
    tick();
    check("crit_beat1", {dc_wen, dcdone, fill_idx}, {1'b1, 1'b1, 3'd0});
    {bus_rvalid, bus_rlast} = '0;
    tick();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
